// File: rtl/xsyw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xsyw_pkg
// Description : Shared definitions for the xsyw approximate signed multiplier.
//               Holds the width helper for the truncation-depth field, the
//               Baugh-Wooley bit-inversion and constant helpers, and the pure
//               reference function that defines the exact approximate result.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package xsyw_pkg;

  // Width of the truncation-depth field for operand width w.
  function automatic int kw(input int w);
    return $clog2(2 * w);
  endfunction

  // One Baugh-Wooley matrix bit at (i, j). Bits where exactly one index is
  // the sign position are inverted; the sign*sign bit is kept as-is.
  function automatic logic bw_bit(input int w, input int i, input int j,
                                  input logic xi, input logic yj);
    logic b;
    b = xi & yj;
    if ((i == w - 1) != (j == w - 1)) begin
      b = ~b;
    end
    return b;
  endfunction

  // Baugh-Wooley correction constants: a 1 at column w and at column 2w-1.
  function automatic logic [127:0] bw_const(input int w);
    return (128'd1 << w) | (128'd1 << (2 * w - 1));
  endfunction

  // Golden model: sum of all matrix bits at column >= ke plus the constants,
  // reduced mod 2^(2w). Valid for w up to 64.
  function automatic logic [127:0] xsyw_ref(input int w, input logic [63:0] x,
                                            input logic [63:0] y, input int ke);
    logic [127:0] acc;
    logic [127:0] mask;
    acc = bw_const(w);
    for (int i = 0; i < w; i++) begin
      for (int j = 0; j < w; j++) begin
        if ((i + j) >= ke && bw_bit(w, i, j, x[i], y[j])) begin
          acc = acc + (128'd1 << (i + j));
        end
      end
    end
    mask = (2 * w >= 128) ? '1 : ((128'd1 << (2 * w)) - 128'd1);
    return acc & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xsyw_pp_csa.sv
`default_nettype none
// ============================================================================
// Module      : xsyw_pp_csa
// Description : Combinational masked Baugh-Wooley partial-product generation
//               followed by a carry-save reduction to two 2W-bit rows. Every
//               matrix bit in a column below ke is forced to zero; the
//               correction constants are always kept. sum + carry (mod
//               2^2W) is the approximate product.
// Ports       : x, y   - signed operands (W bits)
//               ke     - effective truncation depth (already clamped)
//               sum    - carry-save sum row (2W bits)
//               carry  - carry-save carry row (2W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module xsyw_pp_csa
  import xsyw_pkg::*;
#(
  parameter int W  = 16,
  parameter int KW = kw(W)
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic [KW-1:0]  ke,
  output logic [2*W-1:0] sum,
  output logic [2*W-1:0] carry
);

  localparam logic [2*W-1:0] C_CONST = (2*W)'(bw_const(W));

  // pp_row[i][j] is the masked bit x_i*y_j, which lives at column i+j.
  logic [W-1:0][W-1:0]   pp_row;
  // rows[0..W-1] are the shifted partial-product rows, rows[W] the constants.
  logic [W:0][2*W-1:0]   rows;

  for (genvar i = 0; i < W; i++) begin : g_row
    for (genvar j = 0; j < W; j++) begin : g_col
      // Column i+j always fits in KW bits since i+j <= 2W-2 < 2^KW.
      assign pp_row[i][j] = bw_bit(W, i, j, x[i], y[j]) & (ke <= KW'(i + j));
    end
    assign rows[i] = (2*W)'(pp_row[i]) << i;
  end

  assign rows[W] = C_CONST;

  // Chain of 3:2 compressors: each stage folds one more row into the
  // running (s, c) pair. Carries shifted out of bit 2W-1 are dropped,
  // which is exactly the mod 2^2W wrap of the final result.
  for (genvar r = 0; r < W - 1; r++) begin : g_csa
    logic [2*W-1:0] a;
    logic [2*W-1:0] b;
    logic [2*W-1:0] s;
    logic [2*W-1:0] c;
    if (r == 0) begin : g_first
      assign a = rows[0];
      assign b = rows[1];
    end else begin : g_next
      assign a = g_csa[r-1].s;
      assign b = g_csa[r-1].c;
    end
    assign s = a ^ b ^ rows[r+2];
    assign c = ((a & b) | (a & rows[r+2]) | (b & rows[r+2])) << 1;
  end

  assign sum   = g_csa[W-2].s;
  assign carry = g_csa[W-2].c;

endmodule
`default_nettype wire

// File: rtl/xsyw_pipe_mul.sv
`default_nettype none
// ============================================================================
// Module      : xsyw_pipe_mul
// Description : Three-stage pipelined W x W signed approximate multiplier with
//               per-beat truncation depth and valid/ready streaming.
//               S1 registers operands, clamped depth and tag; S2 registers the
//               carry-save rows; S3 registers the final sum and tag.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               in_valid/in_ready    - input handshake
//               x, y                 - signed operands (W bits)
//               k                    - requested truncation depth
//               tag_in               - user tag travelling with the beat
//               out_valid/out_ready  - output handshake
//               z                    - approximate product (2W bits)
//               tag_out              - tag of the beat on z
// Revision    : 1.0 - initial release
// ============================================================================
module xsyw_pipe_mul
  import xsyw_pkg::*;
#(
  parameter int W    = 16,
  parameter int KMAX = 12,
  parameter int TAGW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      x,
  input  logic [W-1:0]      y,
  input  logic [kw(W)-1:0]  k,
  input  logic [TAGW-1:0]   tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    z,
  output logic [TAGW-1:0]   tag_out
);

  localparam int             KW     = kw(W);
  localparam logic [KW-1:0]  KMAX_K = KW'(KMAX);

  // Stage valid bits
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

  // Stage 1 data
  logic [W-1:0]    x1_q, x1_d, y1_q, y1_d;
  logic [KW-1:0]   ke1_q, ke1_d;
  logic [TAGW-1:0] tag1_q, tag1_d;

  // Stage 2 data
  logic [2*W-1:0]  sum2_q, sum2_d, carry2_q, carry2_d;
  logic [TAGW-1:0] tag2_q, tag2_d;

  // Stage 3 data (reset to zero so z/tag_out read 0 after reset)
  logic [2*W-1:0]  z_q, z_d;
  logic [TAGW-1:0] tag3_q, tag3_d;

  // Per-stage "may load this cycle", resolved back from out_ready.
  logic s1_ready, s2_ready, s3_ready;
  logic [KW-1:0] ke_in;

  logic [2*W-1:0] csa_sum, csa_carry;

  xsyw_pp_csa #(
    .W  (W),
    .KW (KW)
  ) u_pp_csa (
    .x     (x1_q),
    .y     (y1_q),
    .ke    (ke1_q),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  always_comb begin
    s3_ready = !v3_q || out_ready;
    s2_ready = !v2_q || s3_ready;
    s1_ready = !v1_q || s2_ready;

    ke_in = (k > KMAX_K) ? KMAX_K : k;

    v1_d = s1_ready ? in_valid : v1_q;
    v2_d = s2_ready ? v1_q     : v2_q;
    v3_d = s3_ready ? v2_q     : v3_q;

    x1_d     = x1_q;
    y1_d     = y1_q;
    ke1_d    = ke1_q;
    tag1_d   = tag1_q;
    sum2_d   = sum2_q;
    carry2_d = carry2_q;
    tag2_d   = tag2_q;
    z_d      = z_q;
    tag3_d   = tag3_q;

    if (s1_ready && in_valid) begin
      x1_d   = x;
      y1_d   = y;
      ke1_d  = ke_in;
      tag1_d = tag_in;
    end

    if (s2_ready && v1_q) begin
      sum2_d   = csa_sum;
      carry2_d = csa_carry;
      tag2_d   = tag1_q;
    end

    // Only load from a valid S2 so z stays 0 (not stale data) until the
    // first real result arrives.
    if (s3_ready && v2_q) begin
      z_d    = sum2_q + carry2_q;
      tag3_d = tag2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      z_q    <= '0;
      tag3_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      z_q    <= z_d;
      tag3_q <= tag3_d;
    end
  end

  always_ff @(posedge clk) begin
    x1_q     <= x1_d;
    y1_q     <= y1_d;
    ke1_q    <= ke1_d;
    tag1_q   <= tag1_d;
    sum2_q   <= sum2_d;
    carry2_q <= carry2_d;
    tag2_q   <= tag2_d;
  end

  assign in_ready  = s1_ready;
  assign out_valid = v3_q;
  assign z         = z_q;
  assign tag_out   = tag3_q;

endmodule
`default_nettype wire

// File: tb/tb_xsyw_pipe_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_xsyw_pipe_mul
// Description : Self-checking bench for xsyw_pipe_mul. Expected results are
//               queued when a beat is accepted and compared when a result is
//               accepted downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xsyw_pipe_mul;
  import xsyw_pkg::*;

  localparam int W      = 16;
  localparam int KMAX   = 12;
  localparam int TAGW   = 4;
  localparam int KW     = kw(W);
  localparam int N_RAND = 10000;

  typedef struct packed {
    logic [2*W-1:0]  z;
    logic [TAGW-1:0] tag;
    logic [2*W-1:0]  ex;
    logic [2*W-1:0]  bnd;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    x;
  logic [W-1:0]    y;
  logic [KW-1:0]   k;
  logic [TAGW-1:0] tag_in;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  z;
  logic [TAGW-1:0] tag_out;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Snapshot taken by cycle() just before the active edge.
  logic            s_ifire, s_ofire, s_ovalid, s_iready;
  logic [2*W-1:0]  s_z;
  logic [TAGW-1:0] s_tag;
  int              s_occ;

  always #5 clk = ~clk;

  xsyw_pipe_mul #(
    .W    (W),
    .KMAX (KMAX),
    .TAGW (TAGW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .k         (k),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .tag_out   (tag_out)
  );

  function automatic exp_t make_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [KW-1:0] kk, input logic [TAGW-1:0] t);
    exp_t e;
    int ke;
    logic [127:0] r;
    logic signed [2*W-1:0] as, bs;
    ke = (int'(kk) > KMAX) ? KMAX : int'(kk);
    r = xsyw_ref(W, 64'(a), 64'(b), ke);
    e.z = r[2*W-1:0];
    e.tag = t;
    as = $signed(a);
    bs = $signed(b);
    e.ex = as * bs;
    e.bnd = '0;
    for (int c = 0; c < ke; c++) begin
      e.bnd = e.bnd + ((2*W)'(c + 1) << c);
    end
    return e;
  endfunction

  // Inputs are set right after a falling edge; sample #1 later, record the
  // transfers that the coming rising edge will perform, then move on to the
  // next falling edge.
  task automatic cycle();
    #1;
    s_ovalid = out_valid;
    s_iready = in_ready;
    s_z      = z;
    s_tag    = tag_out;
    s_ofire  = out_valid && out_ready && !rst;
    s_ifire  = in_valid && in_ready && !rst;
    s_occ    = exp_q.size();
    if (s_ifire) exp_q.push_back(make_exp(x, y, k, tag_in));
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle();
    n_cmp++; if (s_ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", s_ovalid); end
    n_cmp++; if (s_iready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", s_iready); end
    n_cmp++; if (s_z !== '0) begin n_fail++; $display("FAIL reset_z: got %h want 0", s_z); end
    n_cmp++; if (s_tag !== '0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", s_tag); end
  endtask

  task automatic test_directed();
    logic [W-1:0]   dx [3] = '{16'hFFFF, 16'h7FFF, 16'h00FF};
    logic [W-1:0]   dy [3] = '{16'hFFFF, 16'h8000, 16'h00FF};
    logic [KW-1:0]  dk [3] = '{5'd0, 5'd0, 5'd8};
    logic [2*W-1:0] dz [3] = '{32'h0000_0001, 32'hC000_8000, 32'h0000_F700};
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      in_valid = 1'b1;
      x = dx[v];
      y = dy[v];
      k = dk[v];
      tag_in = TAGW'(v + 5);
      cycle();
      n_cmp++; if (s_iready !== 1'b1) begin n_fail++; $display("FAIL dir_in_ready[%0d]: got %b want 1", v, s_iready); end
      in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        cycle();
        n_cmp++;
        if (s_ovalid !== (c == 3)) begin
          n_fail++; $display("FAIL dir_latency[%0d] cycle %0d: out_valid got %b want %b", v, c, s_ovalid, (c == 3));
        end
        if (s_ofire && exp_q.size() != 0) void'(exp_q.pop_front());
        if (c == 3) begin
          n_cmp++;
          if (s_z !== dz[v] || s_tag !== TAGW'(v + 5)) begin
            n_fail++; $display("FAIL dir_z[%0d]: got z=%h tag=%h want z=%h tag=%h", v, s_z, s_tag, dz[v], TAGW'(v + 5));
          end
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_kmax_random();
    int sent = 0;
    int cyc = 0;
    exp_t e;
    logic signed [2*W-1:0] err;
    in_valid = 1'b0;
    s_ifire = 1'b0;
    while ((sent < N_RAND || exp_q.size() != 0) && cyc < 80000) begin
      if (!in_valid || s_ifire) begin
        if (sent < N_RAND && $urandom_range(3) != 0) begin
          in_valid = 1'b1;
          if (sent < 2) begin
            // Same operands at k=31 and k=12 must give the same result.
            x = 16'hA5C3;
            y = 16'h3C7E;
            k = (sent == 0) ? KW'(31) : KW'(12);
          end else begin
            x = W'($urandom);
            y = W'($urandom);
            k = KW'($urandom);
          end
          tag_in = TAGW'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(3) != 0);
      cycle();
      cyc++;
      if (s_ifire) sent++;
      if (s_ofire) begin
        n_cmp++;
        if (s_occ == 0) begin
          n_fail++; $display("FAIL rand_unexpected: got z=%h tag=%h with nothing in flight", s_z, s_tag);
        end else begin
          e = exp_q.pop_front();
          if (s_z !== e.z || s_tag !== e.tag) begin
            n_fail++; $display("FAIL rand_z: got z=%h tag=%h want z=%h tag=%h", s_z, s_tag, e.z, e.tag);
          end
          n_cmp++;
          err = $signed(e.ex) - $signed(s_z);
          if (err < 0 || err > $signed(e.bnd)) begin
            n_fail++; $display("FAIL rand_err_bound: got z=%h exact=%h allowed error 0..%0d", s_z, e.ex, e.bnd);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (sent != N_RAND || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_complete: got sent=%0d pending=%0d want sent=%0d pending=0", sent, exp_q.size(), N_RAND);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    exp_t e;
    logic pv = 1'b0;
    logic por = 1'b1;
    logic [2*W-1:0] pz = '0;
    logic [TAGW-1:0] ptag = '0;
    in_valid = 1'b0;
    s_ifire = 1'b0;
    while ((sent < 100 || exp_q.size() != 0) && cyc < 2000) begin
      if (!in_valid || s_ifire) begin
        if (sent < 100) begin
          in_valid = 1'b1;
          x = W'($urandom);
          y = W'($urandom);
          k = KW'($urandom);
          tag_in = TAGW'(sent);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = 1'($urandom_range(1));
      cycle();
      cyc++;
      if (s_ifire) sent++;
      n_cmp++;
      if (s_iready !== ((s_occ < 3) || out_ready)) begin
        n_fail++; $display("FAIL b2b_in_ready: got %b want %b (held=%0d out_ready=%b)", s_iready, ((s_occ < 3) || out_ready), s_occ, out_ready);
      end
      if (pv && !por) begin
        n_cmp++;
        if (s_ovalid !== 1'b1 || s_z !== pz || s_tag !== ptag) begin
          n_fail++; $display("FAIL b2b_hold: got v=%b z=%h tag=%h want v=1 z=%h tag=%h", s_ovalid, s_z, s_tag, pz, ptag);
        end
      end
      if (s_ofire) begin
        n_cmp++;
        if (s_occ == 0) begin
          n_fail++; $display("FAIL b2b_unexpected: got tag=%h with nothing in flight", s_tag);
        end else begin
          e = exp_q.pop_front();
          got++;
          if (s_z !== e.z || s_tag !== e.tag) begin
            n_fail++; $display("FAIL b2b_order: got z=%h tag=%h want z=%h tag=%h", s_z, s_tag, e.z, e.tag);
          end
        end
      end
      pv = s_ovalid; por = out_ready; pz = s_z; ptag = s_tag;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got != 100 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: got %0d results pending=%0d want 100 pending=0", got, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_k_change_stalled();
    int klist [8] = '{0, 9, 31, 4, 12, 2, 7, 15};
    exp_t e;
    int got = 0;
    x = 16'hB6D5;
    y = 16'h5A3F;
    for (int c = 0; c < 18; c++) begin
      in_valid = (c < 8);
      k = KW'(klist[c % 8]);
      tag_in = TAGW'(c);
      out_ready = (c >= 5);
      cycle();
      n_cmp++;
      if (s_iready !== ((s_occ < 3) || out_ready)) begin
        n_fail++; $display("FAIL kchg_in_ready[%0d]: got %b want %b", c, s_iready, ((s_occ < 3) || out_ready));
      end
      if (s_ofire) begin
        n_cmp++;
        if (s_occ == 0) begin
          n_fail++; $display("FAIL kchg_unexpected: got tag=%h with nothing in flight", s_tag);
        end else begin
          e = exp_q.pop_front();
          got++;
          if (s_z !== e.z || s_tag !== e.tag) begin
            n_fail++; $display("FAIL kchg_z: got z=%h tag=%h want z=%h tag=%h", s_z, s_tag, e.z, e.tag);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got != 6 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL kchg_count: got %0d results pending=%0d want 6 pending=0", got, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      x = W'($urandom);
      y = W'($urandom);
      k = KW'($urandom);
      tag_in = TAGW'(c + 9);
      cycle();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (exp_q.size() != 3) begin
      n_fail++; $display("FAIL rstmid_fill: got %0d beats accepted want 3", exp_q.size());
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_q.delete();
    cycle();
    n_cmp++; if (s_ovalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", s_ovalid); end
    n_cmp++; if (s_iready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", s_iready); end
    n_cmp++; if (s_z !== '0) begin n_fail++; $display("FAIL rstmid_z: got %h want 0", s_z); end
    n_cmp++; if (s_tag !== '0) begin n_fail++; $display("FAIL rstmid_tag: got %h want 0", s_tag); end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      n_cmp++;
      if (s_ovalid !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_ghost[%0d]: got out_valid=%b tag=%h want out_valid=0", c, s_ovalid, s_tag);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    y = '0;
    k = '0;
    tag_in = '0;
    s_ifire = 1'b0;
    test_reset();
    test_directed();
    test_kmax_random();
    test_back_to_back();
    test_k_change_stalled();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached after %0d comparisons", n_cmp);
    $fatal(1, "time limit reached");
  end

endmodule
`default_nettype wire
